// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the pipeline memory stage.
//   XLEN          - default datapath width
//   mem_state_e   - data-bus access FSM states (IDLE, WAIT_RESP)
//   RES_*         - ResultSrc encodings selecting the writeback value
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_RESP = 1'b1
    } mem_state_e;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

endpackage

// File: rtl/memory_stage_ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register.
// Captures the EX-stage results on every rising edge where en=1 and holds
// them otherwise; asynchronous active-low reset clears every field to 0.
// Ports:
//   clk, rst                     - clock, async active-low reset
//   en                           - load enable (0 = hold)
//   *_e                          - EX-stage values in
//   *_m                          - registered MEM-stage values out
module ex_mem_reg
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            reg_write_e,
    input  logic            mem_write_e,
    input  logic [1:0]      result_src_e,
    input  logic [4:0]      rd_e,
    input  logic [XLEN-1:0] alu_result_e,
    input  logic [XLEN-1:0] write_data_e,
    input  logic [XLEN-1:0] pc_plus4_e,
    output logic            reg_write_m,
    output logic            mem_write_m,
    output logic [1:0]      result_src_m,
    output logic [4:0]      rd_m,
    output logic [XLEN-1:0] alu_result_m,
    output logic [XLEN-1:0] write_data_m,
    output logic [XLEN-1:0] pc_plus4_m
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            result_src_m <= RES_ALU;
            rd_m         <= '0;
            alu_result_m <= '0;
            write_data_m <= '0;
            pc_plus4_m   <= '0;
        end else if (en) begin
            reg_write_m  <= reg_write_e;
            mem_write_m  <= mem_write_e;
            result_src_m <= result_src_e;
            rd_m         <= rd_e;
            alu_result_m <= alu_result_e;
            write_data_m <= write_data_e;
            pc_plus4_m   <= pc_plus4_e;
        end
    end

endmodule

// File: rtl/memory_stage.sv
// memory_stage: MEM stage of a 5-stage RISC-V pipeline plus the MEM/WB
// register and writeback result mux.
//
// Optional feature: define MEM_MISALIGN_CHECK_EN to add output MisalignM.
// A word access whose address has bits [1:0] != 0 is then suppressed (no bus
// request, no stall) and written back as a bubble. Without the macro the low
// address bits go to the bus unchecked.
//
// Ports:
//   clk, rst             - clock, async active-low reset
//   *E                   - EX-stage results (captured into EX/MEM when StallM=0)
//   ALUResultM/RdM/RegWriteM - MEM-stage forwarding sources
//   StallM               - M access incomplete; freezes IF/ID/EX and EX/MEM
//   dmem_*               - data-bus request / response
//   RegWriteW/RdW/ResultW - writeback result and control
//   MisalignM            - misaligned access flag (MEM_MISALIGN_CHECK_EN only)
//   state_dbg            - current access FSM state
//
// Data-bus handshake: dmem_req with dmem_we/dmem_addr/dmem_wdata is held
// stable until a cycle where dmem_gnt=1; that cycle is the transfer. A store
// is finished at its grant. A load is finished by a later single-cycle
// dmem_rvalid carrying dmem_rdata; rvalid is only honoured in WAIT_RESP.
module memory_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteE,
    input  logic            MemWriteE,
    input  logic [1:0]      ResultSrcE,
    input  logic [4:0]      RdE,
    input  logic [XLEN-1:0] ALUResultE,
    input  logic [XLEN-1:0] WriteDataE,
    input  logic [XLEN-1:0] PCPlus4E,
    output logic [XLEN-1:0] ALUResultM,
    output logic [4:0]      RdM,
    output logic            RegWriteM,
    output logic            StallM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            RegWriteW,
    output logic [4:0]      RdW,
    output logic [XLEN-1:0] ResultW,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic            MisalignM,
`endif
    output mem_state_e      state_dbg
);

    // EX/MEM register
    logic            MemWriteM;
    logic [1:0]      ResultSrcM;
    logic [XLEN-1:0] WriteDataM;
    logic [XLEN-1:0] PCPlus4M;
    logic            ex_mem_en;

    assign ex_mem_en = !StallM;

    ex_mem_reg #(.XLEN(XLEN)) u_ex_mem (
        .clk          (clk),
        .rst          (rst),
        .en           (ex_mem_en),
        .reg_write_e  (RegWriteE),
        .mem_write_e  (MemWriteE),
        .result_src_e (ResultSrcE),
        .rd_e         (RdE),
        .alu_result_e (ALUResultE),
        .write_data_e (WriteDataE),
        .pc_plus4_e   (PCPlus4E),
        .reg_write_m  (RegWriteM),
        .mem_write_m  (MemWriteM),
        .result_src_m (ResultSrcM),
        .rd_m         (RdM),
        .alu_result_m (ALUResultM),
        .write_data_m (WriteDataM),
        .pc_plus4_m   (PCPlus4M)
    );

    // Access decode. A store takes priority if both encodings appear.
    logic is_store;
    logic is_load;
    logic access;
    logic misalign;
    logic pending;

    assign is_store = MemWriteM;
    assign is_load  = (ResultSrcM == RES_MEM) && !MemWriteM;
    assign access   = is_store || is_load;

`ifdef MEM_MISALIGN_CHECK_EN
    assign misalign  = access && (ALUResultM[1:0] != 2'b00);
    assign MisalignM = misalign;
`else
    assign misalign  = 1'b0;
`endif

    // A misaligned access never reaches the bus.
    assign pending = access && !misalign;

    // Access FSM
    mem_state_e state;
    mem_state_e state_next;
    logic       store_done;
    logic       load_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        dmem_req   = 1'b0;
        store_done = 1'b0;
        load_done  = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    dmem_req = 1'b1;
                    if (dmem_gnt) begin
                        if (is_store) begin
                            store_done = 1'b1;
                        end else begin
                            state_next = WAIT_RESP;
                        end
                    end
                end
            end
            WAIT_RESP: begin
                // EX/MEM is frozen here, so the load is still the M instruction.
                if (dmem_rvalid) begin
                    load_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign state_dbg  = state;
    assign StallM     = pending && !(store_done || load_done);
    assign dmem_we    = dmem_req && MemWriteM;
    assign dmem_addr  = ALUResultM;
    assign dmem_wdata = WriteDataM;

    // MEM/WB register
    logic [1:0]      ResultSrcW;
    logic [XLEN-1:0] ALUResultW;
    logic [XLEN-1:0] ReadDataW;
    logic [XLEN-1:0] PCPlus4W;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            RdW        <= '0;
            ResultSrcW <= RES_ALU;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
        end else begin
            if (StallM) begin
                // Bubble: only the write enable matters downstream.
                RegWriteW <= 1'b0;
            end else begin
                RegWriteW  <= RegWriteM && !misalign;
                RdW        <= RdM;
                ResultSrcW <= ResultSrcM;
                ALUResultW <= ALUResultM;
                PCPlus4W   <= PCPlus4M;
            end
            if (load_done) begin
                ReadDataW <= dmem_rdata;
            end
        end
    end

    always_comb begin
        ResultW = '0;
        case (ResultSrcW)
            RES_ALU: ResultW = ALUResultW;
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: self-checking bench for memory_stage.
// Instructions are driven into E; a program-order reference model predicts
// every writeback ({rd, result}) into exp_q; a monitor pops and compares
// whenever RegWriteW=1. A bus slave process answers requests with a
// configurable or random grant delay and read latency.
// Build with MEM_MISALIGN_CHECK_EN defined to exercise MisalignM.
module tb_memory_stage;
    import riscv_pkg::*;

    localparam int W  = 32;
    localparam int EW = 5 + W;

    typedef struct packed {
        logic         rw;
        logic         mw;
        logic [1:0]   src;
        logic [4:0]   rd;
        logic [W-1:0] alu;
        logic [W-1:0] wd;
        logic [W-1:0] pc4;
    } instr_t;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // DUT signals
    logic         RegWriteE, MemWriteE;
    logic [1:0]   ResultSrcE;
    logic [4:0]   RdE;
    logic [W-1:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [W-1:0] ALUResultM;
    logic [4:0]   RdM;
    logic         RegWriteM, StallM;
    logic         dmem_req, dmem_we;
    logic [W-1:0] dmem_addr, dmem_wdata;
    logic         dmem_gnt, dmem_rvalid;
    logic [W-1:0] dmem_rdata;
    logic         RegWriteW;
    logic [4:0]   RdW;
    logic [W-1:0] ResultW;
`ifdef MEM_MISALIGN_CHECK_EN
    logic         MisalignM;
`endif
    mem_state_e   state_dbg;

    memory_stage dut (
        .clk        (clk),
        .rst        (rst),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .ResultSrcE (ResultSrcE),
        .RdE        (RdE),
        .ALUResultE (ALUResultE),
        .WriteDataE (WriteDataE),
        .PCPlus4E   (PCPlus4E),
        .ALUResultM (ALUResultM),
        .RdM        (RdM),
        .RegWriteM  (RegWriteM),
        .StallM     (StallM),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_gnt   (dmem_gnt),
        .dmem_rvalid(dmem_rvalid),
        .dmem_rdata (dmem_rdata),
        .RegWriteW  (RegWriteW),
        .RdW        (RdW),
        .ResultW    (ResultW),
`ifdef MEM_MISALIGN_CHECK_EN
        .MisalignM  (MisalignM),
`endif
        .state_dbg  (state_dbg)
    );

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    logic [W-1:0]  ref_mem[16];
    logic [W-1:0]  slave_mem[16];
    int n_vec  = 0;
    int n_fail = 0;
    int stall_cnt = 0;
    int req_cnt   = 0;
    int rv_seen   = 0;

    // slave knobs
    bit auto_mode = 1'b0;
    int gnt_lat   = 0;
    int rv_lat    = 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic instr_t mk(input logic rw, input logic mw, input logic [1:0] src,
                                  input logic [4:0] rd, input logic [W-1:0] alu,
                                  input logic [W-1:0] wd, input logic [W-1:0] pc4);
        instr_t i;
        i.rw = rw; i.mw = mw; i.src = src; i.rd = rd;
        i.alu = alu; i.wd = wd; i.pc4 = pc4;
        return i;
    endfunction

    task automatic drive(input instr_t i);
        RegWriteE  = i.rw;
        MemWriteE  = i.mw;
        ResultSrcE = i.src;
        RdE        = i.rd;
        ALUResultE = i.alu;
        WriteDataE = i.wd;
        PCPlus4E   = i.pc4;
    endtask

    // Reference model: instruction-level, in program order.
    task automatic model(input instr_t i, input bit aborted);
        bit mis;
        bit is_acc;
        logic [W-1:0] res;
        is_acc = i.mw || (i.src == 2'b01);
        mis = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = is_acc && (i.alu[1:0] != 2'b00);
`endif
        if (i.mw && !mis && !aborted) ref_mem[i.alu[5:2]] = i.wd;
        if (i.rw && !mis && !aborted) begin
            case (i.src)
                2'b00:   res = i.alu;
                2'b01:   res = ref_mem[i.alu[5:2]];
                2'b10:   res = i.pc4;
                default: res = '0;
            endcase
            exp_q.push_back({i.rd, res});
        end
    endtask

    // Issue one instruction: wait (bounded) until the stage accepts, driving
    // junk in E meanwhile, then hand the instruction to the model.
    task automatic issue(input instr_t i, input bit aborted);
        int budget;
        budget = 0;
        @(negedge clk); #2;
        while (StallM && budget < 200) begin
            drive(mk(1'b1, 1'b0, 2'b00, 5'($urandom_range(0, 31)), $urandom(), $urandom(), $urandom()));
            budget++;
            @(negedge clk); #2;
        end
        if (StallM) begin
            n_vec++;
            n_fail++;
            $display("FAIL issue_timeout: StallM still 1 after %0d cycles, expected 0", budget);
        end else begin
            drive(i);
            model(i, aborted);
        end
        @(posedge clk); #1;
        drive(mk(1'b0, 1'b0, 2'b00, 5'd0, '0, '0, '0));
    endtask

    task automatic nops(input int n);
        for (int k = 0; k < n; k++) issue(mk(1'b0, 1'b0, 2'b00, 5'd0, '0, '0, '0), 1'b0);
    endtask

    // bus slave
    initial begin : slave
        int wait_left;
        int rv_cnt;
        bit in_req;
        logic [W-1:0] rv_data;
        for (int k = 0; k < 16; k++) slave_mem[k] = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        wait_left = 0; rv_cnt = 0; in_req = 1'b0; rv_data = '0;
        forever begin
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom();
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rv_data;
                end
            end else if (dmem_req) begin
                if (!in_req) begin
                    in_req = 1'b1;
                    wait_left = auto_mode ? $urandom_range(0, 3) : gnt_lat;
                end
                if (wait_left == 0) begin
                    dmem_gnt = 1'b1;
                    in_req   = 1'b0;
                    if (dmem_we) begin
                        slave_mem[dmem_addr[5:2]] = dmem_wdata;
                    end else begin
                        rv_data = slave_mem[dmem_addr[5:2]];
                        rv_cnt  = auto_mode ? $urandom_range(1, 4) : rv_lat;
                    end
                end else begin
                    wait_left--;
                end
            end else begin
                in_req = 1'b0;
                // stray response while nothing is outstanding
                if (auto_mode && $urandom_range(0, 7) == 0) dmem_rvalid = 1'b1;
            end
        end
    end

    // monitor: writeback scoreboard, request-hold check, event counters
    initial begin : monitor
        logic [EW-1:0] exp;
        logic [EW-1:0] act;
        logic [W*2:0]  held;
        bit            held_v;
        held = '0; held_v = 1'b0;
        forever begin
            @(negedge clk); #1;
            if (RegWriteW) begin
                act = {RdW, ResultW};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL wb_unexpected: got rd=%0d result=%h, expected no writeback", RdW, ResultW);
                end else begin
                    exp = exp_q.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL wb_value: got rd=%0d result=%h, expected rd=%0d result=%h",
                                 act[EW-1:W], act[W-1:0], exp[EW-1:W], exp[W-1:0]);
                    end
                end
            end
            if (!rst || !dmem_req) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    n_vec++;
                    if ({dmem_we, dmem_addr, dmem_wdata} !== held) begin
                        n_fail++;
                        $display("FAIL req_hold: got %h, expected %h", {dmem_we, dmem_addr, dmem_wdata}, held);
                    end
                end
                held   = {dmem_we, dmem_addr, dmem_wdata};
                held_v = !dmem_gnt;
            end
            if (StallM) stall_cnt++;
            if (dmem_req) req_cnt++;
            if (dmem_rvalid) rv_seen++;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    // main stimulus
    initial begin : main
        int s0, r0, v0, budget;
        instr_t ins;
        logic [W-1:0] addr;
        for (int k = 0; k < 16; k++) ref_mem[k] = '0;
        rst = 1'b0;
        drive(mk(1'b0, 1'b0, 2'b00, 5'd0, '0, '0, '0));
        repeat (3) @(negedge clk);
        #1;
        chk("rst_regwritew", 64'(RegWriteW), 64'd0);
        chk("rst_resultw",   64'(ResultW),   64'd0);
        chk("rst_rdw",       64'(RdW),       64'd0);
        chk("rst_req",       64'(dmem_req),  64'd0);
        chk("rst_stall",     64'(StallM),    64'd0);
        chk("rst_alum",      64'(ALUResultM), 64'd0);
        chk("rst_regwritem", 64'(RegWriteM), 64'd0);
        chk("rst_state",     64'(state_dbg), 64'(IDLE));
        @(negedge clk); #1;
        rst = 1'b1;

        // store, grant same cycle: one request cycle, no stall
        s0 = stall_cnt; r0 = req_cnt;
        issue(mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h100, 32'hDEADBEEF, 32'h0), 1'b0);
        #1;
        chk("st_req",   64'(dmem_req),   64'd1);
        chk("st_we",    64'(dmem_we),    64'd1);
        chk("st_addr",  64'(dmem_addr),  64'h100);
        chk("st_wdata", 64'(dmem_wdata), 64'hDEADBEEF);
        nops(2);
        chk("st_req_cycles", 64'(req_cnt - r0),   64'd1);
        chk("st_stalls",     64'(stall_cnt - s0), 64'd0);
        chk("st_mem",        64'(slave_mem[0]),   64'hDEADBEEF);

        // load 0x104, grant same cycle, rvalid 3 cycles later
        issue(mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h104, 32'h12345678, 32'h0), 1'b0);
        rv_lat = 3;
        s0 = stall_cnt;
        issue(mk(1'b1, 1'b0, 2'b01, 5'd9, 32'h104, 32'h0, 32'h0), 1'b0);
        nops(2);
        chk("ld_stalls", 64'(stall_cnt - s0), 64'd3);

        // store with grant delayed 4 cycles; E junk during the stall
        gnt_lat = 4;
        s0 = stall_cnt; r0 = req_cnt;
        issue(mk(1'b0, 1'b1, 2'b00, 5'd0, 32'h108, 32'hCAFEF00D, 32'h0), 1'b0);
        nops(2);
        chk("dly_req_cycles", 64'(req_cnt - r0),   64'd5);
        chk("dly_stalls",     64'(stall_cnt - s0), 64'd4);
        chk("dly_mem",        64'(slave_mem[2]),   64'hCAFEF00D);
        gnt_lat = 0;

        // ALU op then jal, no stalls
        s0 = stall_cnt;
        issue(mk(1'b1, 1'b0, 2'b00, 5'd5, 32'h2A, 32'h0, 32'h0), 1'b0);
        issue(mk(1'b1, 1'b0, 2'b10, 5'd1, 32'h77, 32'h0, 32'h40), 1'b0);
        issue(mk(1'b1, 1'b0, 2'b11, 5'd2, 32'h55, 32'h0, 32'h66), 1'b0);
        nops(2);
        chk("alu_stalls", 64'(stall_cnt - s0), 64'd0);

        // reset while waiting for a load response
        rv_lat = 6;
        issue(mk(1'b1, 1'b0, 2'b01, 5'd7, 32'h108, 32'h0, 32'h0), 1'b1);
        @(negedge clk);
        @(negedge clk); #1;
        chk("abort_state_wait", 64'(state_dbg), 64'(WAIT_RESP));
        v0 = rv_seen;
        rst = 1'b0;
        #1;
        chk("abort_state_idle", 64'(state_dbg), 64'(IDLE));
        chk("abort_req",        64'(dmem_req),  64'd0);
        chk("abort_regwritew",  64'(RegWriteW), 64'd0);
        chk("abort_stall",      64'(StallM),    64'd0);
        @(negedge clk); #1;
        rst = 1'b1;
        repeat (8) @(negedge clk);
        #2;
        chk("abort_rvalid_seen", 64'(rv_seen - v0 > 0), 64'd1);
        chk("abort_state_after", 64'(state_dbg), 64'(IDLE));
        chk("abort_regwritew2",  64'(RegWriteW), 64'd0);
        rv_lat = 1;

        // load at a non-word-aligned address
        issue(mk(1'b1, 1'b0, 2'b01, 5'd3, 32'h102, 32'h0, 32'h0), 1'b0);
        #1;
`ifdef MEM_MISALIGN_CHECK_EN
        chk("mis_flag",  64'(MisalignM), 64'd1);
        chk("mis_req",   64'(dmem_req),  64'd0);
        chk("mis_stall", 64'(StallM),    64'd0);
`else
        chk("unal_req",  64'(dmem_req),  64'd1);
        chk("unal_addr", 64'(dmem_addr), 64'h102);
`endif
        nops(2);

        // randomized traffic
        auto_mode = 1'b1;
        for (int n = 0; n < 300; n++) begin
            addr = 32'h100 + 32'(4 * $urandom_range(0, 15));
`ifdef MEM_MISALIGN_CHECK_EN
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
`endif
            ins = mk(1'b1, 1'b0, 2'b00, 5'($urandom_range(0, 31)), $urandom(), $urandom(), $urandom());
            case ($urandom_range(0, 9))
                0, 1, 2: ;
                3:       ins.rw = 1'b0;
                4:       ins.src = 2'b10;
                5:       ins.src = 2'b11;
                6, 7:    begin ins.src = 2'b01; ins.alu = addr; end
                default: begin ins.mw = 1'b1; ins.rw = 1'b0; ins.alu = addr; end
            endcase
            issue(ins, 1'b0);
        end
        auto_mode = 1'b0;
        nops(3);
        budget = 0;
        while (exp_q.size() != 0 && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
